seg7_bus_responder: RTL and testbench
=====================================

Name: seg7_bus_responder

Overview:
Memory-mapped 4-digit seven-segment display peripheral; it is the responder end of the CPU peripheral bus that drives seg_o/an_o on the board.
- The CPU (initiator) writes a 16-bit hex value and control bits.
- The block time-multiplexes the digits on the active-low common-anode display.
- It sits beside the LED, switch and button peripherals and runs on the 10 MHz system clock domain.

Parameters:
CLK_HZ, 10_000_000, input clock frequency in Hz
REFRESH_HZ, 1000, full-frame rate (all 4 digits) in Hz; DIV = CLK_HZ/(REFRESH_HZ*4) cycles per digit, DIV >= 2 is required (elaboration error otherwise)

Ports:
clk_i  input  1  system clock, 10 MHz
rst_i  input  1  synchronous active-high reset
we_i  input  1  write request strobe, one cycle per request
re_i  input  1  read request strobe, one cycle per request
addr_i  input  4  byte address: 0x0 DATA, 0x4 CTRL, 0x8 STATUS
wdata_i  input  32  write data
rdata_o  output  32  read data, valid only while ack_o=1
ack_o  output  1  one-cycle acknowledge
seg_o  output  7  segments {g,f,e,d,c,b,a}, active low
an_o  output  4  digit anodes, active low; bit i = digit i

Behaviour:
- Clock and reset: single clock clk_i; reset is synchronous and active-high on rst_i.
- Reset values:
  - DATA=0x0000; CTRL.EN=1, CTRL.BLANK=4'b0000.
  - Prescaler and digit index = 0.
  - seg_o=7'h7F, an_o=4'hF, ack_o=0, rdata_o=0.
- Register map:
  - DATA[15:0]: R/W; nibble i shown on digit i (digit 0 = rightmost).
  - CTRL: bit0 EN, bits[7:4] BLANK (1 = digit i always off); other bits read 0.
  - STATUS: bits[1:0] current digit index; read-only, writes ignored.
- Bus handshake:
  - A request is any cycle with we_i|re_i=1.
  - ack_o=1 exactly one cycle after each request, for one cycle; back-to-back requests are each acked in consecutive cycles.
  - A write commits at the request edge.
  - rdata_o holds the register value sampled at the request edge during the ack cycle; it is 0 in all other cycles.
  - we_i and re_i both high: treated as a write; ack once; rdata_o=0.
  - Unmapped address (including 0xC, or any address with addr_i[1:0] != 0): write ignored, read returns 0, ack still given.
  - Writes to bits[31:16] of DATA are ignored.
  - Reset asserted during a pending ack: ack_o=0 next cycle; the write is discarded if the reset and the request are in the same cycle.
- Scan engine:
  - Prescaler counts 0..DIV-1.
  - On the cycle the prescaler equals DIV-1, it wraps to 0 and the index advances 0→1→2→3→0.
  - an_o and seg_o are registered from the current index, DATA, CTRL and the decode, so they update together, 1 cycle after the index changes. No mixed-digit cycle is allowed.
  - Active digit: an_o = ~(4'b1 << idx), seg_o = decode(nibble idx).
  - BLANK[idx]=1: an_o=4'hF and seg_o=7'h7F for that slot; the scan timing is unchanged.
  - EN=0: prescaler and index are held at 0; an_o=4'hF, seg_o=7'h7F from the next cycle.
  - EN 0→1: scan starts at digit 0 with a full DIV-cycle slot.
  - DATA/CTRL written mid-slot: the new value is visible on seg_o/an_o on the cycle after the ack cycle; the slot timing is not reset.
- Decode table (active low, hex gfedcba), nibble 0..F:
  - 0..7: 40, 79, 24, 30, 19, 12, 02, 78
  - 8..F: 00, 10, 08, 03, 46, 21, 06, 0E

Optional Feature:
SEG7_LZB_EN
- Defined: leading-zero blanking. Digits 3..1 are blanked while they and all higher digits are nibble 0. Digit 0 is never blanked by this rule. It is ORed with CTRL.BLANK; e.g. DATA=0x0050 lights digits 1 and 0 only.
- Undefined: all enabled digits are shown, including leading zeros; no extra logic is present.

Test Plan:
- Reset, then release with CLK_HZ=400, REFRESH_HZ=25 (DIV=4) → seg_o=7'h40 on every slot; an_o cycles E,D,B,7, each for 4 cycles, repeating.
- Write DATA=0x1234 at addr 0x0 → ack_o high exactly 1 cycle later; digit0 slot shows seg_o=7'h19, digit3 slot shows 7'h79; read of 0x0 returns 0x00001234 with ack.
- Write CTRL=0x21 (EN=1, BLANK digit1) → digit1 slot an_o=F, seg_o=7F; other slots unchanged; STATUS read returns the index matching the current an_o.
- Write CTRL=0x00 mid-slot → an_o=F, seg_o=7F from the next cycle; write CTRL=0x01 → first lit slot is digit 0 (an_o=E) for 4 cycles.
- we_i=re_i=1 to addr 0x0 with wdata 0xABCD → DATA=0xABCD, one ack, rdata_o=0; read of addr 0xC → ack with rdata 0; 3 consecutive requests → 3 consecutive acks.
- With SEG7_LZB_EN, DATA=0x0050 → digits 3 and 2 dark; digit1 seg_o=7'h12; digit0 seg_o=7'h40. With DATA=0x0000 → only digit0 lit.

Source files
------------

// File: rtl/seg7_bus_responder.sv
// Bus-mapped 4-digit seven-segment scanner (DATA/CTRL/STATUS registers, one-cycle ack).
// Optional leading-zero blanking is compiled in when SEG7_LZB_EN is defined.
module seg7_bus_responder #(
  parameter int CLK_HZ     = 10_000_000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic [6:0]  seg_o,
  output logic [3:0]  an_o
);

  localparam int DIV = CLK_HZ / (REFRESH_HZ * 4);
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("seg7_bus_responder: CLK_HZ/(REFRESH_HZ*4) must be >= 2");
    end
  endgenerate

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_CTRL   = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;

  logic [15:0]   r_data;
  logic          r_en;
  logic [3:0]    r_blank;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic          r_ack;
  logic [31:0]   r_rdata;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;

  logic [31:0]   w_rdata;
  logic [3:0]    w_nibble;
  logic [3:0]    w_blank;
  logic          w_unused_wdata;

  assign w_unused_wdata = ^wdata_i[31:16];

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Read value is the register content before any write landing on the same edge.
  always_comb begin
    w_rdata = 32'h0;
    case (addr_i)
      ADDR_DATA:   w_rdata = {16'h0, r_data};
      ADDR_CTRL:   w_rdata = {24'h0, r_blank, 3'b000, r_en};
      ADDR_STATUS: w_rdata = {30'h0, r_idx};
      default:     w_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data  <= 16'h0000;
      r_en    <= 1'b1;
      r_blank <= 4'b0000;
      r_ack   <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_ack   <= we_i | re_i;
      r_rdata <= (re_i && !we_i) ? w_rdata : 32'h0;
      if (we_i) begin
        if (addr_i == ADDR_DATA) begin
          r_data <= wdata_i[15:0];
        end else if (addr_i == ADDR_CTRL) begin
          r_en    <= wdata_i[0];
          r_blank <= wdata_i[7:4];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !r_en) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_comb begin
    w_nibble = r_data[3:0];
    case (r_idx)
      2'd0:    w_nibble = r_data[3:0];
      2'd1:    w_nibble = r_data[7:4];
      2'd2:    w_nibble = r_data[11:8];
      default: w_nibble = r_data[15:12];
    endcase
  end

`ifdef SEG7_LZB_EN
  // A digit is a leading zero only if it and every digit above it are zero.
  logic [3:0] w_lzb;
  assign w_lzb[3] = (r_data[15:12] == 4'h0);
  genvar gi;
  generate
    for (gi = 2; gi >= 1; gi--) begin : g_lzb
      assign w_lzb[gi] = w_lzb[gi+1] & (r_data[gi*4 +: 4] == 4'h0);
    end
  endgenerate
  assign w_lzb[0] = 1'b0;
  assign w_blank  = r_blank | w_lzb;
`else
  assign w_blank = r_blank;
`endif

  // Anode and segment registers share one enable so a digit never shows another's pattern.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
    end else if (!r_en || w_blank[r_idx]) begin
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
    end else begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= seg_decode(w_nibble);
    end
  end

  assign ack_o   = r_ack;
  assign rdata_o = r_rdata;
  assign seg_o   = r_seg;
  assign an_o    = r_an;

endmodule

// File: tb/tb_seg7_bus_responder.sv
// Scoreboarded bench for seg7_bus_responder at DIV=4 (CLK_HZ=400, REFRESH_HZ=25).
module tb_seg7_bus_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        we_i;
  logic        re_i;
  logic [3:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic [6:0]  seg_o;
  logic [3:0]  an_o;

  seg7_bus_responder #(.CLK_HZ(400), .REFRESH_HZ(25)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .we_i(we_i), .re_i(re_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o), .seg_o(seg_o), .an_o(an_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge of the ack cycle with strobes dropped.
  task automatic req(input logic we, input logic re, input logic [3:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd);
    exp_t e;
    we_i = we; re_i = re; addr_i = addr; wdata_i = wd;
    e.due = cyc + 1;
    e.rdata = exp_rd;
    exp_q.push_back(e);
    $display("req  we=%0b re=%0b addr=0x%0h wdata=0x%0h exp_rdata=0x%0h", we, re, addr, wd, exp_rd);
    @(negedge clk_i);
    we_i = 1'b0; re_i = 1'b0;
  endtask

  // Starts at the first cycle of the digit-0 slot; checks 16 cycles (one full frame).
  task automatic check_frame(input string name, input logic [15:0] ans, input logic [27:0] segs);
    for (int i = 0; i < 16; i++) begin
      int k;
      k = i / 4;
      chk($sformatf("%s an[%0d]", name, i), {28'h0, an_o}, {28'h0, ans[k*4 +: 4]});
      chk($sformatf("%s seg[%0d]", name, i), {25'h0, seg_o}, {25'h0, segs[k*7 +: 7]});
      @(negedge clk_i);
    end
  endtask

  // Disable, load DATA, re-enable: scan restarts at digit 0 on a known cycle.
  task automatic restart_with(input logic [15:0] data);
    req(1'b1, 1'b0, 4'h4, 32'h0, 32'h0);
    req(1'b1, 1'b0, 4'h0, {16'h0, data}, 32'h0);
    req(1'b1, 1'b0, 4'h4, 32'h1, 32'h0);
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; we_i = 1'b0; re_i = 1'b0; addr_i = 4'h0; wdata_i = 32'h0;

    // Monitor: every ack must match the oldest outstanding request, on its due cycle.
    fork
      forever begin
        @(negedge clk_i);
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          total++; bad++;
          $display("FAIL ack_missing: got=no ack expected=ack at cycle %0d (now %0d)", exp_q[0].due, cyc);
          void'(exp_q.pop_front());
        end
        if (ack_o === 1'b1) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL ack_spurious: got=ack expected=no ack (cycle %0d)", cyc);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ack_cycle", cyc, e.due);
            chk("ack_rdata", rdata_o, e.rdata);
          end
        end else begin
          chk("idle_rdata", rdata_o, 32'h0);
        end
      end
    join_none

    repeat (3) @(negedge clk_i);
    chk("rst_an", {28'h0, an_o}, 32'hF);
    chk("rst_seg", {25'h0, seg_o}, 32'h7F);
    chk("rst_ack", {31'h0, ack_o}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);

    rst_i = 1'b0;
    @(negedge clk_i);
    check_frame("zero_f0", 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h40});
    check_frame("zero_f1", 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h40});

    // Disable, then load 0x1234 while dark; reads see disabled CTRL and held index.
    req(1'b1, 1'b0, 4'h4, 32'h0, 32'h0);
    req(1'b1, 1'b0, 4'h0, 32'h1234, 32'h0);
    chk("dis_an", {28'h0, an_o}, 32'hF);
    chk("dis_seg", {25'h0, seg_o}, 32'h7F);
    req(1'b0, 1'b1, 4'h0, 32'h0, 32'h1234);
    req(1'b0, 1'b1, 4'h4, 32'h0, 32'h0);
    req(1'b0, 1'b1, 4'h8, 32'h0, 32'h0);
    req(1'b1, 1'b0, 4'h4, 32'h1, 32'h0);
    @(negedge clk_i);
    check_frame("d1234", 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19});

    // Blank digit 1 via CTRL=0x21, then STATUS follows the scan.
    req(1'b1, 1'b0, 4'h4, 32'h0, 32'h0);
    req(1'b1, 1'b0, 4'h4, 32'h21, 32'h0);
    @(negedge clk_i);
    check_frame("blank1", 16'h7BFE, {7'h79, 7'h24, 7'h7F, 7'h19});
    chk("status_an0", {28'h0, an_o}, 32'hE);
    req(1'b0, 1'b1, 4'h8, 32'h0, 32'h0);
    repeat (3) @(negedge clk_i);
    req(1'b0, 1'b1, 4'h8, 32'h0, 32'h1);
    req(1'b0, 1'b1, 4'h4, 32'h0, 32'h21);

    // Disable mid-slot: dark from the cycle after the ack; re-enable restarts at digit 0.
    req(1'b1, 1'b0, 4'h4, 32'h0, 32'h0);
    @(negedge clk_i);
    chk("off_an0", {28'h0, an_o}, 32'hF);
    chk("off_seg0", {25'h0, seg_o}, 32'h7F);
    @(negedge clk_i);
    chk("off_an1", {28'h0, an_o}, 32'hF);
    req(1'b1, 1'b0, 4'h4, 32'h1, 32'h0);
    @(negedge clk_i);
    check_frame("reen", 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19});

    // Combined strobe, unmapped addresses, back-to-back requests.
    req(1'b1, 1'b1, 4'h0, 32'hABCD, 32'h0);
    req(1'b0, 1'b1, 4'h0, 32'h0, 32'hABCD);
    req(1'b0, 1'b1, 4'hC, 32'h0, 32'h0);
    req(1'b0, 1'b1, 4'h1, 32'h0, 32'h0);
    req(1'b1, 1'b0, 4'h2, 32'h5555, 32'h0);
    req(1'b0, 1'b1, 4'h0, 32'h0, 32'hABCD);
    req(1'b0, 1'b1, 4'h4, 32'h0, 32'h1);
    restart_with(16'hABCD);
    check_frame("dABCD", 16'h7BDE, {7'h08, 7'h03, 7'h46, 7'h21});
    req(1'b1, 1'b0, 4'h0, 32'hFFFF5678, 32'h0);
    req(1'b0, 1'b1, 4'h0, 32'h0, 32'h5678);

`ifdef SEG7_LZB_EN
    restart_with(16'h0050);
    check_frame("lzb0050", 16'hFFDE, {7'h7F, 7'h7F, 7'h12, 7'h40});
    restart_with(16'h0000);
    check_frame("lzb0000", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40});
`else
    restart_with(16'h0050);
    check_frame("nolzb0050", 16'h7BDE, {7'h40, 7'h40, 7'h12, 7'h40});
    restart_with(16'h0000);
    check_frame("nolzb0000", 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h40});
`endif

    // Reset in the same cycle as a write: no ack, write lost, registers at reset values.
    req(1'b1, 1'b0, 4'h0, 32'h0000_0999, 32'h0);
    rst_i = 1'b1; we_i = 1'b1; addr_i = 4'h0; wdata_i = 32'h7777;
    @(negedge clk_i);
    we_i = 1'b0;
    chk("rst_req_ack", {31'h0, ack_o}, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    req(1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
    req(1'b0, 1'b1, 4'h4, 32'h0, 32'h1);

    repeat (3) @(negedge clk_i);
    chk("drain", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
